// File: rtl/spu_dual_issue_router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spu_dual_issue_router_pkg
// Description : Shared opcode, pipe-class and issue-record types plus the
//               opcode classification helpers used by the dual-issue router.
// Revision    : 1.0 - initial release
// ============================================================================
package spu_dual_issue_router_pkg;

    localparam int SPU_REG_W = 7;
    localparam int SPU_IMM_W = 18;
    localparam int SPU_OP_W  = 7;

    typedef enum logic [SPU_OP_W-1:0] {
        OP_ILLEGAL                = 7'd0,
        OP_ADD_WORD               = 7'd1,
        OP_AND                    = 7'd13,
        OP_OR                     = 7'd17,
        OP_MULTIPLY               = 7'd57,
        OP_LOAD_QUADWORD_AFORM    = 7'd81,
        OP_STOP_AND_SIGNAL        = 7'd92,
        OP_NO_OPERATION_EXECUTE   = 7'd93,
        OP_NO_OPERATION_LOAD      = 7'd94
    } spu_opcode_e;

    typedef enum logic {
        PIPE_EVEN = 1'b0,
        PIPE_ODD  = 1'b1
    } spu_pipe_e;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_SECOND = 2'd1,
        ST_HALT   = 2'd2
    } router_state_e;

    typedef struct packed {
        logic [SPU_OP_W-1:0]  op;
        logic [SPU_REG_W-1:0] rt;
        logic [SPU_REG_W-1:0] ra;
        logic [SPU_REG_W-1:0] rb;
        logic [SPU_REG_W-1:0] rc;
        logic [SPU_IMM_W-1:0] imm;
        logic [3:0]           src;   // {ra, rb, rc, rt-as-source}
    } issue_rec_t;

    // Undefined encodings are issued as an even-pipe no-op.
    function automatic logic [SPU_OP_W-1:0] legal_op(input logic [SPU_OP_W-1:0] op);
        if (op >= 7'd1 && op <= 7'd94) begin
            return op;
        end
        return OP_NO_OPERATION_EXECUTE;
    endfunction

    function automatic spu_pipe_e pipe_of(input logic [SPU_OP_W-1:0] op);
        if (op == 7'd27 || op == 7'd28 || (op >= 7'd67 && op <= 7'd92) || op == 7'd94) begin
            return PIPE_ODD;
        end
        return PIPE_EVEN;
    endfunction

    function automatic logic writes_rt(input logic [SPU_OP_W-1:0] op);
        return !((op >= 7'd82 && op <= 7'd85) || (op >= 7'd88 && op <= 7'd94)) &&
               (op >= 7'd1 && op <= 7'd94);
    endfunction

    function automatic logic is_branch(input logic [SPU_OP_W-1:0] op);
        return (op >= 7'd84 && op <= 7'd91);
    endfunction

    function automatic logic is_stop(input logic [SPU_OP_W-1:0] op);
        return (op == OP_STOP_AND_SIGNAL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spu_dual_issue_router_if.sv
`default_nettype none
// ============================================================================
// Module      : spu_dual_issue_router_if
// Description : Decoder-to-issue pair bus and even/odd pipe issue bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface spu_dual_issue_router_if #(
    parameter int REG_W = 7,
    parameter int IMM_W = 18,
    parameter int OP_W  = 7
);
    logic             flush;
    logic             out_stall;
    logic             in_valid;
    logic             in_ready;
    logic             in0_v,   in1_v;
    logic [OP_W-1:0]  in0_op,  in1_op;
    logic [REG_W-1:0] in0_rt,  in1_rt;
    logic [REG_W-1:0] in0_ra,  in1_ra;
    logic [REG_W-1:0] in0_rb,  in1_rb;
    logic [REG_W-1:0] in0_rc,  in1_rc;
    logic [3:0]       in0_src, in1_src;
    logic [IMM_W-1:0] in0_imm, in1_imm;

    logic             even_valid, odd_valid;
    logic [OP_W-1:0]  even_op,  odd_op;
    logic [REG_W-1:0] even_rt,  odd_rt;
    logic [REG_W-1:0] even_ra,  odd_ra;
    logic [REG_W-1:0] even_rb,  odd_rb;
    logic [REG_W-1:0] even_rc,  odd_rc;
    logic [IMM_W-1:0] even_imm, odd_imm;
    logic [3:0]       even_src, odd_src;
    logic             halted;

    modport master (
        output flush, out_stall, in_valid,
        output in0_v, in0_op, in0_rt, in0_ra, in0_rb, in0_rc, in0_src, in0_imm,
        output in1_v, in1_op, in1_rt, in1_ra, in1_rb, in1_rc, in1_src, in1_imm,
        input  in_ready, halted,
        input  even_valid, even_op, even_rt, even_ra, even_rb, even_rc, even_imm, even_src,
        input  odd_valid,  odd_op,  odd_rt,  odd_ra,  odd_rb,  odd_rc,  odd_imm,  odd_src
    );

    modport slave (
        input  flush, out_stall, in_valid,
        input  in0_v, in0_op, in0_rt, in0_ra, in0_rb, in0_rc, in0_src, in0_imm,
        input  in1_v, in1_op, in1_rt, in1_ra, in1_rb, in1_rc, in1_src, in1_imm,
        output in_ready, halted,
        output even_valid, even_op, even_rt, even_ra, even_rb, even_rc, even_imm, even_src,
        output odd_valid,  odd_op,  odd_rt,  odd_ra,  odd_rb,  odd_rc,  odd_imm,  odd_src
    );
endinterface
`default_nettype wire

// File: rtl/spu_dual_issue_router_pair_hazard_check.sv
`default_nettype none
// ============================================================================
// Module      : spu_pair_hazard_check
// Description : Combinational pair classifier: pipe class per slot and
//               whether the older/younger pair may issue together.
// Revision    : 1.0 - initial release
// ============================================================================
module spu_pair_hazard_check
    import spu_dual_issue_router_pkg::*;
(
    input  issue_rec_t i_rec0,
    input  issue_rec_t i_rec1,
    output logic       o_dual_ok,
    output spu_pipe_e  o_pipe0,
    output spu_pipe_e  o_pipe1
);
    logic w_raw;
    logic w_waw;
    logic w_unused;

    always_comb begin
        o_pipe0 = pipe_of(i_rec0.op);
        o_pipe1 = pipe_of(i_rec1.op);
        // Younger slot reads a field that the older slot is about to write.
        w_raw = writes_rt(i_rec0.op) &&
                ((i_rec1.src[3] && (i_rec1.ra == i_rec0.rt)) ||
                 (i_rec1.src[2] && (i_rec1.rb == i_rec0.rt)) ||
                 (i_rec1.src[1] && (i_rec1.rc == i_rec0.rt)) ||
                 (i_rec1.src[0] && (i_rec1.rt == i_rec0.rt)));
        w_waw = writes_rt(i_rec0.op) && writes_rt(i_rec1.op) && (i_rec0.rt == i_rec1.rt);
        o_dual_ok = (o_pipe0 != o_pipe1) && !w_raw && !w_waw &&
                    !is_branch(i_rec0.op) && !is_stop(i_rec0.op);
    end

    assign w_unused = ^{i_rec0.ra, i_rec0.rb, i_rec0.rc, i_rec0.imm, i_rec0.src, i_rec1.imm};

endmodule
`default_nettype wire

// File: rtl/spu_dual_issue_router.sv
`default_nettype none
// ============================================================================
// Module      : spu_dual_issue_router
// Description : Dual-issue stage routing an in-order instruction pair to the
//               even/odd pipes, serialising through a hold register.
// Revision    : 1.0 - initial release
// ============================================================================
module spu_dual_issue_router
    import spu_dual_issue_router_pkg::*;
#(
    parameter int REG_W = SPU_REG_W,
    parameter int IMM_W = SPU_IMM_W,
    parameter int OP_W  = SPU_OP_W
)(
    input  logic                   clock,
    input  logic                   reset,
    spu_dual_issue_router_if.slave bus
);
    if (REG_W != SPU_REG_W || IMM_W != SPU_IMM_W || OP_W != SPU_OP_W) begin : g_width_check
        $error("spu_dual_issue_router widths must match spu_dual_issue_router_pkg");
    end

    issue_rec_t    w_rec0, w_rec1;
    logic          w_dual_ok;
    spu_pipe_e     w_pipe0, w_pipe1;
    logic          w_in_ready, w_accept;
    logic          w_iss0_v, w_iss1_v;
    issue_rec_t    w_iss0, w_iss1;
    spu_pipe_e     w_iss0_pipe, w_iss1_pipe;
    router_state_e w_next_state;
    issue_rec_t    w_next_hold;

    router_state_e state_q, state_d;
    issue_rec_t    hold_q, hold_d, even_q, even_d, odd_q, odd_d;
    logic          even_valid_q, even_valid_d, odd_valid_q, odd_valid_d;
    logic          halted_q, halted_d;

    always_comb begin
        w_rec0 = '{op: legal_op(bus.in0_op), rt: bus.in0_rt, ra: bus.in0_ra, rb: bus.in0_rb,
                   rc: bus.in0_rc, imm: bus.in0_imm, src: bus.in0_src};
        w_rec1 = '{op: legal_op(bus.in1_op), rt: bus.in1_rt, ra: bus.in1_ra, rb: bus.in1_rb,
                   rc: bus.in1_rc, imm: bus.in1_imm, src: bus.in1_src};
    end

    spu_pair_hazard_check u_hazard (
        .i_rec0    (w_rec0),
        .i_rec1    (w_rec1),
        .o_dual_ok (w_dual_ok),
        .o_pipe0   (w_pipe0),
        .o_pipe1   (w_pipe1)
    );

    assign w_in_ready = !reset && (state_q == ST_ACCEPT) && !bus.out_stall && !halted_q;
    assign w_accept   = bus.in_valid && w_in_ready && !bus.flush;

    // What would issue on an unstalled, unflushed edge.
    always_comb begin
        w_iss0_v     = 1'b0;
        w_iss1_v     = 1'b0;
        w_iss0       = w_rec0;
        w_iss1       = w_rec1;
        w_iss0_pipe  = w_pipe0;
        w_iss1_pipe  = w_pipe1;
        w_next_state = state_q;
        w_next_hold  = hold_q;
        if (state_q == ST_SECOND) begin
            w_iss0_v     = 1'b1;
            w_iss0       = hold_q;
            w_iss0_pipe  = pipe_of(hold_q.op);
            w_next_state = ST_ACCEPT;
            w_next_hold  = '0;
        end else if (w_accept) begin
            if (bus.in0_v && bus.in1_v && !w_dual_ok) begin
                w_iss0_v = 1'b1;
                if (!is_stop(w_rec0.op)) begin
                    w_next_hold  = w_rec1;
                    w_next_state = ST_SECOND;
                end
            end else begin
                w_iss0_v = bus.in0_v;
                w_iss1_v = bus.in1_v;
            end
        end
        if ((w_iss0_v && is_stop(w_iss0.op)) || (w_iss1_v && is_stop(w_iss1.op))) begin
            w_next_state = ST_HALT;
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        even_d       = even_q;
        odd_d        = odd_q;
        even_valid_d = even_valid_q;
        odd_valid_d  = odd_valid_q;
        halted_d     = halted_q;
        if (bus.flush) begin
            even_valid_d = 1'b0;
            odd_valid_d  = 1'b0;
            if (state_q != ST_HALT) begin
                state_d = ST_ACCEPT;
                hold_d  = '0;
            end
        end else if (!bus.out_stall) begin
            even_valid_d = 1'b0;
            odd_valid_d  = 1'b0;
            state_d      = w_next_state;
            hold_d       = w_next_hold;
            if (w_iss0_v) begin
                if (w_iss0_pipe == PIPE_ODD) begin
                    odd_valid_d = 1'b1;
                    odd_d       = w_iss0;
                end else begin
                    even_valid_d = 1'b1;
                    even_d       = w_iss0;
                end
            end
            if (w_iss1_v) begin
                if (w_iss1_pipe == PIPE_ODD) begin
                    odd_valid_d = 1'b1;
                    odd_d       = w_iss1;
                end else begin
                    even_valid_d = 1'b1;
                    even_d       = w_iss1;
                end
            end
            if (w_next_state == ST_HALT) begin
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_ACCEPT;
            hold_q       <= '0;
            even_q       <= '0;
            odd_q        <= '0;
            even_valid_q <= 1'b0;
            odd_valid_q  <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            even_q       <= even_d;
            odd_q        <= odd_d;
            even_valid_q <= even_valid_d;
            odd_valid_q  <= odd_valid_d;
            halted_q     <= halted_d;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.halted     = halted_q;
    assign bus.even_valid = even_valid_q;
    assign bus.even_op    = even_q.op;
    assign bus.even_rt    = even_q.rt;
    assign bus.even_ra    = even_q.ra;
    assign bus.even_rb    = even_q.rb;
    assign bus.even_rc    = even_q.rc;
    assign bus.even_imm   = even_q.imm;
    assign bus.even_src   = even_q.src;
    assign bus.odd_valid  = odd_valid_q;
    assign bus.odd_op     = odd_q.op;
    assign bus.odd_rt     = odd_q.rt;
    assign bus.odd_ra     = odd_q.ra;
    assign bus.odd_rb     = odd_q.rb;
    assign bus.odd_rc     = odd_q.rc;
    assign bus.odd_imm    = odd_q.imm;
    assign bus.odd_src    = odd_q.src;

endmodule
`default_nettype wire

// File: tb/tb_spu_dual_issue_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_spu_dual_issue_router
// Description : Table-driven scoreboard bench for the dual-issue router.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spu_dual_issue_router;

    typedef struct {
        bit iv, fl, st;
        bit v0; int op0, rt0;
        bit v1; int op1, rt1, ra1, src1;
        bit rdy;
        bit ev; int eop, ert;
        bit ov; int oop, ort;
        bit hlt;
    } vec_t;

    typedef struct {
        int idx;
        bit ev; int eop, ert;
        bit ov; int oop, ort;
        bit hlt;
    } exp_t;

    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;
    exp_t exp_q[$];
    vec_t vecs[$];

    spu_dual_issue_router_if #(.REG_W(7), .IMM_W(18), .OP_W(7)) bus ();

    spu_dual_issue_router #(.REG_W(7), .IMM_W(18), .OP_W(7)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic vec_t mk(input bit iv, fl, st, v0, input int op0, rt0,
                                input bit v1, input int op1, rt1, ra1, src1,
                                input bit rdy, ev, input int eop, ert,
                                input bit ov, input int oop, ort, input bit hlt);
        vec_t m;
        m.iv = iv; m.fl = fl; m.st = st;
        m.v0 = v0; m.op0 = op0; m.rt0 = rt0;
        m.v1 = v1; m.op1 = op1; m.rt1 = rt1; m.ra1 = ra1; m.src1 = src1;
        m.rdy = rdy;
        m.ev = ev; m.eop = eop; m.ert = ert;
        m.ov = ov; m.oop = oop; m.ort = ort;
        m.hlt = hlt;
        return m;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.in_valid  = v.iv;
        bus.flush     = v.fl;
        bus.out_stall = v.st;
        bus.in0_v   = v.v0;
        bus.in0_op  = 7'(v.op0);
        bus.in0_rt  = 7'(v.rt0);
        bus.in0_ra  = '0;
        bus.in0_rb  = '0;
        bus.in0_rc  = '0;
        bus.in0_src = '0;
        bus.in0_imm = 18'(v.rt0 * 3);
        bus.in1_v   = v.v1;
        bus.in1_op  = 7'(v.op1);
        bus.in1_rt  = 7'(v.rt1);
        bus.in1_ra  = 7'(v.ra1);
        bus.in1_rb  = '0;
        bus.in1_rc  = '0;
        bus.in1_src = 4'(v.src1);
        bus.in1_imm = 18'(v.rt1 * 5);
    endtask

    task automatic check_outputs();
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check($sformatf("step%0d even_valid", e.idx), int'(bus.even_valid), int'(e.ev));
            check($sformatf("step%0d odd_valid", e.idx), int'(bus.odd_valid), int'(e.ov));
            check($sformatf("step%0d halted", e.idx), int'(bus.halted), int'(e.hlt));
            if (e.ev) begin
                check($sformatf("step%0d even_op", e.idx), int'(bus.even_op), e.eop);
                check($sformatf("step%0d even_rt", e.idx), int'(bus.even_rt), e.ert);
            end
            if (e.ov) begin
                check($sformatf("step%0d odd_op", e.idx), int'(bus.odd_op), e.oop);
                check($sformatf("step%0d odd_rt", e.idx), int'(bus.odd_rt), e.ort);
            end
        end
    endtask

    // Drive one cycle's inputs; outputs for it are compared one cycle later.
    task automatic step(input vec_t v, input int idx);
        exp_t e;
        @(negedge clock);
        check_outputs();
        drive(v);
        #1;
        check($sformatf("step%0d in_ready", idx), int'(bus.in_ready), int'(v.rdy));
        e.idx = idx;
        e.ev = v.ev; e.eop = v.eop; e.ert = v.ert;
        e.ov = v.ov; e.oop = v.oop; e.ort = v.ort;
        e.hlt = v.hlt;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clock);
        check_outputs();
        reset = 1'b1;
        drive(mk(0,0,0, 0,0,0, 0,0,0,0,0, 0, 0,0,0, 0,0,0, 0));
        #1;
        check("reset in_ready", int'(bus.in_ready), 0);
        @(negedge clock);
        check("reset even_valid", int'(bus.even_valid), 0);
        check("reset odd_valid", int'(bus.odd_valid), 0);
        check("reset halted", int'(bus.halted), 0);
        check("reset even_op", int'(bus.even_op), 0);
        check("reset odd_op", int'(bus.odd_op), 0);
        reset = 1'b0;
        #1;
        check("post-reset in_ready", int'(bus.in_ready), 1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        drive(mk(0,0,0, 0,0,0, 0,0,0,0,0, 0, 0,0,0, 0,0,0, 0));

        //             iv fl st  v0 op0 rt0  v1 op1 rt1 ra1 src  rdy  ev eop ert  ov oop ort  hlt
        vecs.push_back(mk(1,0,0, 1,1,3,    1,81,4,0,0,    1, 1,1,3,    1,81,4,   0));
        vecs.push_back(mk(0,0,0, 0,0,0,    0,0,0,0,0,     1, 0,0,0,    0,0,0,    0));
        vecs.push_back(mk(1,0,0, 1,1,5,    1,13,6,5,8,    1, 1,1,5,    0,0,0,    0));
        vecs.push_back(mk(1,0,0, 1,1,7,    1,81,8,0,0,    0, 1,13,6,   0,0,0,    0));
        vecs.push_back(mk(0,0,0, 0,0,0,    0,0,0,0,0,     1, 0,0,0,    0,0,0,    0));
        vecs.push_back(mk(1,0,0, 1,57,10,  1,17,11,0,0,   1, 1,57,10,  0,0,0,    0));
        vecs.push_back(mk(0,0,0, 0,0,0,    0,0,0,0,0,     0, 1,17,11,  0,0,0,    0));
        vecs.push_back(mk(1,0,0, 1,1,12,   1,82,12,0,1,   1, 1,1,12,   0,0,0,    0));
        vecs.push_back(mk(0,0,0, 0,0,0,    0,0,0,0,0,     0, 0,0,0,    1,82,12,  0));
        vecs.push_back(mk(1,0,0, 1,1,9,    1,81,9,0,0,    1, 1,1,9,    0,0,0,    0));
        vecs.push_back(mk(0,0,0, 0,0,0,    0,0,0,0,0,     0, 0,0,0,    1,81,9,   0));
        vecs.push_back(mk(1,0,0, 1,84,20,  1,1,21,0,0,    1, 0,0,0,    1,84,20,  0));
        vecs.push_back(mk(0,0,0, 0,0,0,    0,0,0,0,0,     0, 1,1,21,   0,0,0,    0));
        vecs.push_back(mk(1,0,0, 1,100,22, 1,81,23,0,0,   1, 1,93,22,  1,81,23,  0));
        vecs.push_back(mk(1,0,0, 0,1,0,    1,81,24,0,0,   1, 0,0,0,    1,81,24,  0));
        vecs.push_back(mk(1,0,0, 1,1,25,   0,81,0,0,0,    1, 1,1,25,   0,0,0,    0));
        vecs.push_back(mk(1,0,0, 0,1,26,   0,81,27,0,0,   1, 0,0,0,    0,0,0,    0));
        vecs.push_back(mk(1,0,0, 1,57,26,  1,17,27,0,0,   1, 1,57,26,  0,0,0,    0));
        for (int i = 0; i < 3; i++) begin
            vecs.push_back(mk(0,0,1, 0,0,0, 0,0,0,0,0,    0, 1,57,26,  0,0,0,    0));
        end
        vecs.push_back(mk(0,0,0, 0,0,0,    0,0,0,0,0,     0, 1,17,27,  0,0,0,    0));
        vecs.push_back(mk(0,0,0, 0,0,0,    0,0,0,0,0,     1, 0,0,0,    0,0,0,    0));
        vecs.push_back(mk(1,0,0, 1,57,28,  1,17,29,0,0,   1, 1,57,28,  0,0,0,    0));
        vecs.push_back(mk(0,1,0, 0,0,0,    0,0,0,0,0,     0, 0,0,0,    0,0,0,    0));
        vecs.push_back(mk(0,0,0, 0,0,0,    0,0,0,0,0,     1, 0,0,0,    0,0,0,    0));
        vecs.push_back(mk(1,1,0, 1,1,30,   1,81,31,0,0,   1, 0,0,0,    0,0,0,    0));
        vecs.push_back(mk(1,0,0, 1,1,32,   1,81,33,0,0,   1, 1,1,32,   1,81,33,  0));
        vecs.push_back(mk(0,1,1, 0,0,0,    0,0,0,0,0,     0, 0,0,0,    0,0,0,    0));
        vecs.push_back(mk(0,0,0, 0,0,0,    0,0,0,0,0,     1, 0,0,0,    0,0,0,    0));
        vecs.push_back(mk(1,0,0, 1,1,40,   1,82,50,40,8,  1, 1,1,40,   0,0,0,    0));
        vecs.push_back(mk(0,0,0, 0,0,0,    0,0,0,0,0,     0, 0,0,0,    1,82,50,  0));
        vecs.push_back(mk(1,0,0, 1,1,41,   1,82,50,41,4,  1, 1,1,41,   1,82,50,  0));
        vecs.push_back(mk(1,0,0, 1,81,42,  1,1,43,0,0,    1, 1,1,43,   1,81,42,  0));

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], i);
        end

        // STOP in the older slot: issues alone, younger is discarded, frontend freezes.
        step(mk(1,0,0, 1,92,0,   1,1,34,0,0,    1, 0,0,0,    1,92,0,   1), 100);
        step(mk(1,0,0, 1,1,35,   1,81,36,0,0,   0, 0,0,0,    0,0,0,    1), 101);
        step(mk(0,1,0, 0,0,0,    0,0,0,0,0,     0, 0,0,0,    0,0,0,    1), 102);
        step(mk(0,0,0, 0,0,0,    0,0,0,0,0,     0, 0,0,0,    0,0,0,    1), 103);
        do_reset();

        // STOP in the younger slot dual-issues with an independent even op.
        step(mk(1,0,0, 1,1,37,   1,92,0,0,0,    1, 1,1,37,   1,92,0,   1), 110);
        step(mk(0,0,0, 0,0,0,    0,0,0,0,0,     0, 0,0,0,    0,0,0,    1), 111);
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
